seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  - Parametrised Mealy serial-pattern detector; generalises the fixed 4-bit detectors to any
//    PAT_W-bit pattern, with runtime overlap/non-overlap mode and an input qualifier.
//  - Sits on a 1-bit serial stream (one bit per valid cycle); flags the final bit of each match
//    in the same cycle. An optional saturating match counter is available for status/debug.
// PARAMETERS
//  PAT_W    4        pattern length in bits, legal 2..16
//  PATTERN  4'b1010  pattern; PATTERN[PAT_W-1] is the first bit received, PATTERN[0] the last
//  CNT_W    8        match counter width (only used with SEQ_DET_MATCH_CNT_EN)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  din        in   1      serial data bit
//  din_valid  in   1      din qualifier; bit consumed only when high
//  overlap    in   1      1 = overlapping matches, 0 = non-overlapping; sampled on the match cycle
//  cnt_clr    in   1      synchronous clear of match_cnt
//  dout       out  1      Mealy match flag, combinational, high on the cycle the last pattern bit arrives
//  match_cnt  out  CNT_W  number of matches since reset/clear, saturating
// BEHAVIOUR
//  - State k in 0..PAT_W-1 = length of the longest suffix of the consumed bits (since reset or the
//    last non-overlap match) that equals the first k bits of PATTERN. Reset state is 0.
//  - dout = din_valid & ~rst & (k == PAT_W-1) & (din == PATTERN[0]); zero-cycle latency from din.
//  - Valid bit, no match: next k = longest prefix of PATTERN that is a suffix of (consumed bits + din),
//    capped at PAT_W-1. Full failure-function behaviour is required for any PATTERN, not only 1010.
//  - Valid bit, match, overlap=1: next k = B, where B is the longest proper border of PATTERN
//    (computed at elaboration). For 1010, B=2.
//  - Valid bit, match, overlap=0: next k = 0, and the history is discarded.
//  - din_valid=0: k holds, dout=0, and din and overlap are ignored.
//  - overlap may change on any cycle. It only matters on a match cycle, and changing it never
//    alters a partial match in progress.
//  - rst=1: k->0 at the edge, dout forced 0 in the same cycle, and match_cnt->0. This applies
//    mid-pattern as well; a partial match is lost.
//  - First cycle after reset release: a detection needs at least PAT_W valid bits.
//  - Outputs during/after reset: dout=0, match_cnt=0.
// CONFIGURATION
//  - SEQ_DET_MATCH_CNT_EN defined:
//    - match_cnt increments by 1 on each cycle with dout=1.
//    - It saturates at 2**CNT_W-1; once saturated it holds, with no wrap.
//    - cnt_clr=1 with no match: next value 0.
//    - cnt_clr=1 on a match cycle: next value 1.
//    - rst has priority over cnt_clr and over a match.
//  - SEQ_DET_MATCH_CNT_EN undefined:
//    - No counter register is built.
//    - match_cnt is tied to 0 and cnt_clr is ignored.
//    - The port list is unchanged.
// TESTING
//  - Clock period 10ns. rst=1 for 1 cycle, then valid din 1,0,1,0,1,0,1,0,1 with overlap=1
//    -> dout=1 on valid bits 4, 6 and 8 only; match_cnt=3.
//  - Same stimulus with overlap=0 -> dout=1 on bits 4 and 8 only; match_cnt=2.
//  - Send 1,0,1 then din_valid=0 for 3 cycles (din toggling), then valid 0
//    -> dout=0 during the gap, dout=1 on the resuming bit.
//  - Send 1,0,1, rst=1 for 1 cycle, then 0 -> no match. Then send 1,0,1,0 -> match on the 4th bit.
//  - Set PAT_W=5, PATTERN=5'b11011, overlap=1, stream 1,1,0,1,1,0,1,1
//    -> dout on bits 5 and 8 (B=2); with overlap=0, only bit 5.
//  - With SEQ_DET_MATCH_CNT_EN and CNT_W=2: cause 5 matches -> match_cnt sticks at 3.
//    Then assert cnt_clr on a match cycle -> match_cnt=1.
//    Also confirm that without the macro match_cnt stays 0.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Mealy serial-pattern detector.
// The state is the length of the longest suffix of the consumed bits that is also a
// prefix of PATTERN (KMP automaton). The next state is derived from PATTERN by
// constant-bounded functions, so the detector works for any pattern, not only 1010.
// dout is combinational: it rises in the same cycle as the last pattern bit.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN adds a saturating match counter.
// Without the macro, match_cnt is tied to 0, cnt_clr is ignored, and the port list stays the same.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int SW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  typedef logic [SW-1:0] state_t;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic first_bit(input int i);
    return PATTERN[PAT_W-1-i];
  endfunction

  // Longest proper border of PATTERN: the resume state after an overlapping match.
  function automatic int border_len();
    int   res;
    logic ok;
    res = 0;
    for (int len = 1; len < PAT_W; len++) begin
      ok = 1'b1;
      for (int m = 0; m < PAT_W - 1; m++) begin
        if ((m < len) && (first_bit(m) != first_bit(PAT_W - len + m))) begin
          ok = 1'b0;
        end
      end
      if (ok) begin
        res = len;
      end
    end
    return res;
  endfunction

  // Failure-function step for a non-matching bit: the longest prefix of PATTERN that is
  // a suffix of (first k pattern bits followed by b), capped at PAT_W-1.
  function automatic state_t advance(input state_t k, input logic b);
    int     ki;
    int     idx;
    logic   ok;
    logic   sb;
    state_t res;
    ki  = int'(k);
    res = '0;
    for (int len = 1; len < PAT_W; len++) begin
      if (len <= ki + 1) begin
        ok = 1'b1;
        for (int m = 0; m < PAT_W - 1; m++) begin
          if (m < len) begin
            idx = ki + 1 - len + m;
            sb  = (idx == ki) ? b : first_bit(idx);
            if (sb != first_bit(m)) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) begin
          res = state_t'(len);
        end
      end
    end
    return res;
  endfunction

  localparam int     BORDER     = border_len();
  localparam state_t LAST_STATE = state_t'(PAT_W - 1);
  localparam state_t RESUME     = state_t'(BORDER);

  state_t k_r;
  state_t k_next_s;
  logic   match_s;

  // Match detection and next partial-match length.
  always_comb begin
    match_s  = din_valid & ~rst & (k_r == LAST_STATE) & (din == PATTERN[0]);
    k_next_s = k_r;
    if (rst) begin
      k_next_s = '0;
    end else if (din_valid) begin
      if (match_s) begin
        k_next_s = overlap ? RESUME : '0;
      end else begin
        k_next_s = advance(k_r, din);
      end
    end else begin
      k_next_s = k_r;
    end
  end

  // Partial-match length register; a reset discards any match in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r <= '0;
    end else begin
      k_r <= k_next_s;
    end
  end

  assign dout = match_s;

`ifdef SEQ_DET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Saturating match counter; reset beats clear, and a clear on a match cycle leaves 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (match_s) begin
      if (cnt_clr) begin
        cnt_r <= CNT_ONE;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_cnt = cnt_r;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized and directed self-checking bench.
// Three detectors share one input stream: 1010 (CNT_W=8), 11011 (CNT_W=8), 1010 (CNT_W=2).
// The reference model keeps the raw history of consumed bits: a match occurs when the
// last PAT_W-1 consumed bits plus the current bit spell the pattern. A non-overlapping
// match discards the history. Counter expectations follow SEQ_DET_MATCH_CNT_EN.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       overlap = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       dout0, dout1, dout2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cnt_clr(cnt_clr), .dout(dout0), .match_cnt(cnt0));
  seq_detector_param #(.PAT_W(5), .PATTERN(5'b11011), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cnt_clr(cnt_clr), .dout(dout1), .match_cnt(cnt1));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .cnt_clr(cnt_clr), .dout(dout2), .match_cnt(cnt2));

  // Per-instance parameters as seen by the model.
  int          pw   [3] = '{4, 5, 4};
  logic [15:0] pat  [3] = '{16'b1010, 16'b11011, 16'b1010};
  int          cmax [3] = '{255, 255, 3};

  // Model state: consumed history (newest bit in LSB), its length, and the counter.
  logic [31:0] hist [3];
  int          hlen [3];
  int          mcnt [3];
  logic [31:0] hist_n [3];
  int          hlen_n [3];
  int          mcnt_n [3];
  bit          armed = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit model_match(input logic [31:0] h, input int hl, input logic d,
                                     input int w, input logic [15:0] p);
    logic [31:0] s;
    logic [31:0] mask;
    if (hl < w - 1) return 1'b0;
    s    = {h[30:0], d};
    mask = (32'd1 << w) - 32'd1;
    return (s & mask) == ({16'd0, p} & mask);
  endfunction

  // Compare every instance against the model each cycle and prepare the model's next state.
  always @(negedge clk) begin
    bit dv [3];
    int cv [3];
    bit m;
    dv = '{dout0, dout1, dout2};
    cv = '{int'(cnt0), int'(cnt1), int'(cnt2)};
    for (int i = 0; i < 3; i++) begin
      m = din_valid && !rst && model_match(hist[i], hlen[i], din, pw[i], pat[i]);
      if (armed) begin
        chk($sformatf("dout%0d", i), int'(dv[i]), int'(m));
`ifdef SEQ_DET_MATCH_CNT_EN
        chk($sformatf("cnt%0d", i), cv[i], mcnt[i]);
`else
        chk($sformatf("cnt%0d", i), cv[i], 0);
`endif
      end
      hist_n[i] = hist[i];
      hlen_n[i] = hlen[i];
      mcnt_n[i] = mcnt[i];
      if (rst) begin
        hist_n[i] = 32'd0;
        hlen_n[i] = 0;
        mcnt_n[i] = 0;
      end else begin
        if (din_valid) begin
          if (m && !overlap) begin
            hist_n[i] = 32'd0;
            hlen_n[i] = 0;
          end else begin
            hist_n[i] = {hist[i][30:0], din};
            hlen_n[i] = (hlen[i] < 31) ? hlen[i] + 1 : 31;
          end
        end
        if (m) mcnt_n[i] = cnt_clr ? 1 : ((mcnt[i] < cmax[i]) ? mcnt[i] + 1 : mcnt[i]);
        else if (cnt_clr) mcnt_n[i] = 0;
      end
    end
  end

  // Commit the model state on the same edge the DUT updates.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      hist[i] <= hist_n[i];
      hlen[i] <= hlen_n[i];
      mcnt[i] <= mcnt_n[i];
    end
    if (rst) armed <= 1'b1;
  end

  // Apply one cycle of inputs shortly after the rising edge, then wait for the falling edge.
  task automatic drive(input logic v, input logic d, input logic o, input logic c, input logic r);
    @(posedge clk);
    #2;
    din_valid = v; din = d; overlap = o; cnt_clr = c; rst = r;
    @(negedge clk);
  endtask

  // One valid bit with hand-computed dout expectations (-1 = not pinned).
  task automatic send(input logic d, input logic o, input logic c, input int e0, input int e1);
    drive(1'b1, d, o, c, 1'b0);
    if (e0 >= 0) chk("lit_dout0", int'(dout0), e0);
    if (e1 >= 0) chk("lit_dout1", int'(dout1), e1);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_rst_dout0", int'(dout0), 0);
  endtask

  int exp3, exp2, exp1;
  logic [8:0] s9 = 9'b101010101;
  logic [7:0] s8 = 8'b11011011;
  int ov_e [9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
  int no_e [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
  int p5_ov [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  int p5_no [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

  initial begin
`ifdef SEQ_DET_MATCH_CNT_EN
    exp3 = 3; exp2 = 2; exp1 = 1;
`else
    exp3 = 0; exp2 = 0; exp1 = 0;
`endif
    // Reset state.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_reset_cnt0", int'(cnt0), 0);

    // 101010101 with overlap: matches on bits 4, 6, 8.
    for (int i = 0; i < 9; i++) send(s9[8-i], 1'b1, 1'b0, ov_e[i], 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_cnt_overlap", int'(cnt0), exp3);

    // Same stream without overlap: matches on bits 4 and 8.
    do_reset();
    for (int i = 0; i < 9; i++) send(s9[8-i], 1'b0, 1'b0, no_e[i], 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_cnt_nonoverlap", int'(cnt0), exp2);

    // Gap of invalid cycles keeps the partial match.
    do_reset();
    send(1'b1, 1'b1, 1'b0, 0, 0);
    send(1'b0, 1'b1, 1'b0, 0, 0);
    send(1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, i[0], 1'b1, 1'b0, 1'b0);
      chk("lit_gap_dout0", int'(dout0), 0);
    end
    send(1'b0, 1'b1, 1'b0, 1, 0);

    // Reset mid-pattern (even on a would-be match bit) loses the partial match.
    do_reset();
    send(1'b1, 1'b1, 1'b0, 0, 0);
    send(1'b0, 1'b1, 1'b0, 0, 0);
    send(1'b1, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("lit_rst_on_match", int'(dout0), 0);
    send(1'b0, 1'b1, 1'b0, 0, 0);
    send(1'b1, 1'b1, 1'b0, 0, 0);
    send(1'b0, 1'b1, 1'b0, 0, 0);
    send(1'b1, 1'b1, 1'b0, 0, 0);
    send(1'b0, 1'b1, 1'b0, 1, 0);

    // 11011 pattern: overlap resumes at border 2.
    do_reset();
    for (int i = 0; i < 8; i++) send(s8[7-i], 1'b1, 1'b0, -1, p5_ov[i]);
    do_reset();
    for (int i = 0; i < 8; i++) send(s8[7-i], 1'b0, 1'b0, -1, p5_no[i]);

    // 2-bit counter saturates after 5 matches; clear on a match cycle leaves 1.
    do_reset();
    for (int i = 0; i < 12; i++) send(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, -1, -1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_cnt_sat", int'(cnt2), exp3);
    send(1'b1, 1'b1, 1'b0, 0, -1);
    send(1'b0, 1'b1, 1'b1, 1, -1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_cnt_clr_match", int'(cnt2), exp1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_cnt_clr", int'(cnt2), 0);

    // Randomized stream, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
